id_ex_stage: RTL



---
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand forwarding select, load-use bubble insertion,
// EX register under valid/ready with flush. Optional IDEX_STALL_CNT_EN adds stall_cnt.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CTRLW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_en,
    input  logic             id_rs2_en,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_wen,
    input  logic             id_is_load,
    input  logic [CTRLW-1:0] id_ctrl,
    input  logic [XLEN-1:0]  rf_rdata1,
    input  logic [XLEN-1:0]  rf_rdata2,
    input  logic             fwd1_ex,
    input  logic             fwd2_ex,
    input  logic             fwd1_mem,
    input  logic             fwd2_mem,
    input  logic [XLEN-1:0]  ex_result,
    input  logic             mem_valid,
    input  logic             mem_rd_wen,
    input  logic [XLEN-1:0]  mem_result,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_src1,
    output logic [XLEN-1:0]  ex_src2,
    output logic [4:0]       ex_rd,
    output logic             ex_rd_wen,
    output logic             ex_is_load,
    output logic [CTRLW-1:0] ex_ctrl
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    logic             ex_valid_q,   ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q,      ex_pc_d;
    logic [XLEN-1:0]  ex_src1_q,    ex_src1_d;
    logic [XLEN-1:0]  ex_src2_q,    ex_src2_d;
    logic [4:0]       ex_rd_q,      ex_rd_d;
    logic             ex_rd_wen_q,  ex_rd_wen_d;
    logic             ex_is_load_q, ex_is_load_d;
    logic [CTRLW-1:0] ex_ctrl_q,    ex_ctrl_d;

    logic            ex_fwd_ok;
    logic            mem_fwd_ok;
    logic            rs1_live;
    logic            rs2_live;
    logic            load_use;
    logic            move;
    logic [XLEN-1:0] src1_sel;
    logic [XLEN-1:0] src2_sel;

    // A load in EX has no data yet, so it can never be an EX-stage forwarding source.
    assign ex_fwd_ok  = ex_valid_q && ex_rd_wen_q && !ex_is_load_q;
    assign mem_fwd_ok = mem_valid && mem_rd_wen;
    assign rs1_live   = id_rs1_en && (id_rs1 != 5'd0);
    assign rs2_live   = id_rs2_en && (id_rs2 != 5'd0);

    function automatic logic [XLEN-1:0] pick_src(
        input logic            live,
        input logic            hit_ex,
        input logic            hit_mem,
        input logic [XLEN-1:0] rf_val
    );
        if (!live)                        return '0;
        else if (hit_ex && ex_fwd_ok)     return ex_result;
        else if (hit_mem && mem_fwd_ok)   return mem_result;
        else                              return rf_val;
    endfunction

    assign src1_sel = pick_src(rs1_live, fwd1_ex, fwd1_mem, rf_rdata1);
    assign src2_sel = pick_src(rs2_live, fwd2_ex, fwd2_mem, rf_rdata2);

    assign load_use = id_valid && ex_valid_q && ex_is_load_q && ex_rd_wen_q &&
                      (ex_rd_q != 5'd0) &&
                      ((rs1_live && fwd1_ex) || (rs2_live && fwd2_ex));
    assign move     = ex_ready || !ex_valid_q;
    assign id_ready = move && !load_use && !flush;

    // NOTE: every _d defaults to its _q first so no path through this block infers a latch.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_src1_d    = ex_src1_q;
        ex_src2_d    = ex_src2_q;
        ex_rd_d      = ex_rd_q;
        ex_rd_wen_d  = ex_rd_wen_q;
        ex_is_load_d = ex_is_load_q;
        ex_ctrl_d    = ex_ctrl_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (move && load_use) begin
            ex_valid_d = 1'b0;
        end else if (move) begin
            ex_valid_d   = id_valid;
            ex_pc_d      = id_pc;
            ex_src1_d    = src1_sel;
            ex_src2_d    = src2_sel;
            ex_rd_d      = id_rd;
            ex_rd_wen_d  = id_rd_wen;
            ex_is_load_d = id_is_load;
            ex_ctrl_d    = id_ctrl;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_src1_q    <= '0;
            ex_src2_q    <= '0;
            ex_rd_q      <= '0;
            ex_rd_wen_q  <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_ctrl_q    <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_src1_q    <= ex_src1_d;
            ex_src2_q    <= ex_src2_d;
            ex_rd_q      <= ex_rd_d;
            ex_rd_wen_q  <= ex_rd_wen_d;
            ex_is_load_q <= ex_is_load_d;
            ex_ctrl_q    <= ex_ctrl_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_src1    = ex_src1_q;
    assign ex_src2    = ex_src2_q;
    assign ex_rd      = ex_rd_q;
    assign ex_rd_wen  = ex_rd_wen_q;
    assign ex_is_load = ex_is_load_q;
    assign ex_ctrl    = ex_ctrl_q;

`ifdef IDEX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (move && load_use && !flush) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
